// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch/jump flushes and memory-wait
// freezing with a timeout into an absorbing error state.
module hazard_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic [1:0]  id_jump,
  input  logic        ex_memread,
  input  logic [4:0]  ex_rd,
  input  logic        ex_branch_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pc_we,
  output logic        ifid_we,
  output logic        idex_we,
  output logic        exmem_we,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic [1:0]  state,
  output logic        mem_timeout,
  output logic [15:0] stall_cycles
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    LU_STALL = 2'b10,
    ERROR    = 2'b11
  } state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t     cur_state;
  state_t     nxt_state;
  logic [7:0] wait_cnt;
  logic [7:0] wait_inc;
  logic       mem_stall;
  logic       load_use;

  assign state     = cur_state;
  assign mem_stall = mem_req & ~mem_ready;
  assign load_use  = id_valid & ex_memread & (ex_rd != 5'd0) &
                     ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt)));
  assign wait_inc  = wait_cnt + 8'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_state <= RUN;
    end else begin
      cur_state <= nxt_state;
    end
  end

  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      RUN: begin
        if (mem_stall)                        nxt_state = MEM_WAIT;
        else if (load_use && !ex_branch_taken) nxt_state = LU_STALL;
        else                                   nxt_state = RUN;
      end
      LU_STALL: nxt_state = mem_stall ? MEM_WAIT : RUN;
      MEM_WAIT: begin
        if (!mem_stall)                   nxt_state = RUN;
        else if (wait_inc == TIMEOUT_CNT) nxt_state = ERROR;
        else                              nxt_state = MEM_WAIT;
      end
      default: nxt_state = ERROR;
    endcase
  end

  // Reset and ERROR force a drained pipeline; otherwise first matching priority wins.
  // The load-use hazard was already serviced by the stall cycle, so LU_STALL ignores it.
  always_comb begin
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    idex_we     = 1'b1;
    exmem_we    = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (rst || cur_state == ERROR) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idex_we     = 1'b0;
      exmem_we    = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (mem_stall) begin
      pc_we    = 1'b0;
      ifid_we  = 1'b0;
      idex_we  = 1'b0;
      exmem_we = 1'b0;
    end else if (ex_branch_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (load_use && cur_state != LU_STALL) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idex_bubble = 1'b1;
    end else if (id_jump != 2'b00) begin
      ifid_flush = 1'b1;
    end
  end

  // Wait counter is held at zero outside MEM_WAIT so every entry starts fresh.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= 8'd0;
    end else if (cur_state != MEM_WAIT) begin
      wait_cnt <= 8'd0;
    end else if (mem_stall) begin
      wait_cnt <= wait_inc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_timeout <= 1'b0;
    end else if (nxt_state == ERROR) begin
      mem_timeout <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= 16'd0;
    end else if (!pc_we && cur_state != ERROR && stall_cycles != 16'hFFFF) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: vector table, hand-written multi-cycle sequences and
// randomized traffic checked against a behavioural model.
module tb_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rt;
  logic [1:0]  id_jump;
  logic        ex_memread;
  logic [4:0]  ex_rd;
  logic        ex_branch_taken;
  logic        mem_req;
  logic        mem_ready;

  logic        pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_bubble;
  logic [1:0]  state;
  logic        mem_timeout;
  logic [15:0] stall_cycles;

  logic        d4_pc_we, d4_ifid_we, d4_idex_we, d4_exmem_we, d4_ifid_flush, d4_idex_bubble;
  logic [1:0]  d4_state;
  logic        d4_mem_timeout;
  logic [15:0] d4_stall_cycles;

  logic [5:0]  outs;
  logic [5:0]  d4_outs;
  assign outs    = {pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_bubble};
  assign d4_outs = {d4_pc_we, d4_ifid_we, d4_idex_we, d4_exmem_we, d4_ifid_flush, d4_idex_bubble};

  localparam int S_RUN = 0, S_WAIT = 1, S_LU = 2, S_ERR = 3;

  int n_checks = 0;
  int n_errors = 0;

  hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .id_jump(id_jump), .ex_memread(ex_memread), .ex_rd(ex_rd),
    .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_we(pc_we), .ifid_we(ifid_we), .idex_we(idex_we), .exmem_we(exmem_we),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .state(state),
    .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
  );

  hazard_ctrl #(.TIMEOUT(4)) dut4 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .id_jump(id_jump), .ex_memread(ex_memread), .ex_rd(ex_rd),
    .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_we(d4_pc_we), .ifid_we(d4_ifid_we), .idex_we(d4_idex_we), .exmem_we(d4_exmem_we),
    .ifid_flush(d4_ifid_flush), .idex_bubble(d4_idex_bubble), .state(d4_state),
    .mem_timeout(d4_mem_timeout), .stall_cycles(d4_stall_cycles)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       id_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rt;
    logic [1:0] id_jump;
    logic       ex_memread;
    logic [4:0] ex_rd;
    logic       ex_branch_taken;
    logic       mem_req;
    logic       mem_ready;
    logic [5:0] exp_out;
    logic [1:0] exp_next;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(logic v, logic [4:0] rs, logic [4:0] rt, logic urt,
                              logic [1:0] jmp, logic mr, logic [4:0] rd, logic br,
                              logic mq, logic my, logic [5:0] eo, logic [1:0] en);
    vec_t r;
    r.id_valid = v; r.id_rs = rs; r.id_rt = rt; r.id_uses_rt = urt; r.id_jump = jmp;
    r.ex_memread = mr; r.ex_rd = rd; r.ex_branch_taken = br; r.mem_req = mq;
    r.mem_ready = my; r.exp_out = eo; r.exp_next = en;
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Driver tasks
  task automatic clear_inputs();
    id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0; id_jump = 0;
    ex_memread = 0; ex_rd = 0; ex_branch_taken = 0; mem_req = 0; mem_ready = 0;
  endtask

  task automatic apply(vec_t v);
    id_valid = v.id_valid; id_rs = v.id_rs; id_rt = v.id_rt; id_uses_rt = v.id_uses_rt;
    id_jump = v.id_jump; ex_memread = v.ex_memread; ex_rd = v.ex_rd;
    ex_branch_taken = v.ex_branch_taken; mem_req = v.mem_req; mem_ready = v.mem_ready;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves time at posedge+1 with rst low; the next edge is the first normal one.
  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Behavioural model: pipeline mode, cycles spent waiting, stall total, error flag.
  int m_mode;
  int m_waited;
  int m_stalls;
  bit m_to;

  task automatic model_reset();
    m_mode = S_RUN; m_waited = 0; m_stalls = 0; m_to = 0;
  endtask

  task automatic model_predict(output logic [5:0] eo, output int nm);
    bit ms, lu;
    ms = mem_req && !mem_ready;
    lu = id_valid && ex_memread && (ex_rd != 0) &&
         ((ex_rd == id_rs) || (id_uses_rt && ex_rd == id_rt));
    if (m_mode == S_ERR) begin
      eo = 6'b000011; nm = S_ERR;
    end else if (ms) begin
      eo = 6'b000000;
      nm = (m_mode == S_WAIT && m_waited + 1 >= 255) ? S_ERR : S_WAIT;
    end else begin
      nm = S_RUN;
      if (ex_branch_taken) eo = 6'b111111;
      else if (lu && m_mode != S_LU) begin
        eo = 6'b001101;
        if (m_mode == S_RUN) nm = S_LU;
      end
      else if (id_jump != 2'b00) eo = 6'b111110;
      else eo = 6'b111100;
    end
  endtask

  task automatic model_commit(logic [5:0] eo, int nm);
    if (nm == S_WAIT) m_waited = (m_mode == S_WAIT) ? m_waited + 1 : 0;
    if (!eo[5] && m_mode != S_ERR && m_stalls < 65535) m_stalls = m_stalls + 1;
    if (nm == S_ERR) m_to = 1;
    m_mode = nm;
  endtask

  initial begin
    logic [5:0] eo;
    int nm;

    rst = 1'b1;
    clear_inputs();
    // {valid, rs, rt, uses_rt, jump, memread, rd, branch, mem_req, mem_ready, outs, next}
    vecs[0]  = mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 6'b111100, 2'd0);
    vecs[1]  = mk(1, 5, 0, 0, 2'b00, 1, 5, 0, 0, 0, 6'b001101, 2'd2);
    vecs[2]  = mk(1, 0, 0, 0, 2'b00, 1, 0, 0, 0, 0, 6'b111100, 2'd0);
    vecs[3]  = mk(1, 1, 7, 1, 2'b00, 1, 7, 0, 0, 0, 6'b001101, 2'd2);
    vecs[4]  = mk(1, 1, 7, 0, 2'b00, 1, 7, 0, 0, 0, 6'b111100, 2'd0);
    vecs[5]  = mk(0, 5, 0, 0, 2'b00, 1, 5, 0, 0, 0, 6'b111100, 2'd0);
    vecs[6]  = mk(1, 5, 0, 0, 2'b01, 1, 5, 1, 0, 0, 6'b111111, 2'd0);
    vecs[7]  = mk(1, 2, 3, 1, 2'b01, 0, 2, 0, 0, 0, 6'b111110, 2'd0);
    vecs[8]  = mk(1, 9, 0, 0, 2'b10, 1, 9, 0, 0, 0, 6'b001101, 2'd2);
    vecs[9]  = mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 0, 6'b000000, 2'd1);
    vecs[10] = mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 1, 6'b111100, 2'd0);
    vecs[11] = mk(1, 5, 0, 0, 2'b01, 1, 5, 1, 1, 0, 6'b000000, 2'd1);
    vecs[12] = mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 6'b111100, 2'd0);
    vecs[13] = mk(0, 0, 0, 0, 2'b00, 0, 0, 1, 0, 0, 6'b111111, 2'd0);

    // Reset state while rst is held
    #2;
    chk("reset_outs", 32'(outs), 32'(6'b000011));
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_timeout", 32'(mem_timeout), 32'd0);
    chk("reset_stalls", 32'(stall_cycles), 32'd0);
    tick();
    rst = 1'b0;

    // Table-driven single-cycle vectors from RUN
    for (int i = 0; i < 14; i++) begin
      do_reset();
      apply(vecs[i]);
      #2;
      chk($sformatf("vec%0d_outs", i), 32'(outs), 32'(vecs[i].exp_out));
      tick();
      chk($sformatf("vec%0d_next", i), 32'(state), 32'(vecs[i].exp_next));
    end

    // Load-use stall lasts one cycle and is masked in LU_STALL
    do_reset();
    id_valid = 1; ex_memread = 1; ex_rd = 5'd5; id_rs = 5'd5;
    #2;
    chk("lu_outs", 32'(outs), 32'(6'b001101));
    tick();
    chk("lu_state", 32'(state), 32'(S_LU));
    chk("lu_stalls", 32'(stall_cycles), 32'd1);
    #2;
    chk("lu_masked_outs", 32'(outs), 32'(6'b111100));
    tick();
    chk("lu_back_run", 32'(state), 32'(S_RUN));

    // Memory wait of 3 cycles; branch held during the wait acts at release
    do_reset();
    mem_req = 1; mem_ready = 0; ex_branch_taken = 1;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk($sformatf("mw_outs%0d", i), 32'(outs), 32'(6'b000000));
      tick();
      chk($sformatf("mw_state%0d", i), 32'(state), 32'(S_WAIT));
    end
    mem_ready = 1;
    #2;
    chk("mw_release_outs", 32'(outs), 32'(6'b111111));
    tick();
    chk("mw_release_state", 32'(state), 32'(S_RUN));
    chk("mw_stalls", 32'(stall_cycles), 32'd3);

    // Timeout on the TIMEOUT=4 instance
    do_reset();
    mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 4; i++) tick();
    chk("to_still_wait", 32'(d4_state), 32'(S_WAIT));
    chk("to_flag_low", 32'(d4_mem_timeout), 32'd0);
    tick();
    chk("to_error", 32'(d4_state), 32'(S_ERR));
    chk("to_flag", 32'(d4_mem_timeout), 32'd1);
    mem_req = 0; mem_ready = 1;
    for (int i = 0; i < 5; i++) tick();
    #2;
    chk("to_absorb_state", 32'(d4_state), 32'(S_ERR));
    chk("to_absorb_flag", 32'(d4_mem_timeout), 32'd1);
    chk("to_err_outs", 32'(d4_outs), 32'(6'b000011));
    chk("to_stalls", 32'(d4_stall_cycles), 32'd5);
    rst = 1'b1;
    #1;
    chk("to_async_state", 32'(d4_state), 32'(S_RUN));
    chk("to_async_flag", 32'(d4_mem_timeout), 32'd0);
    tick();
    rst = 1'b0;

    // Asynchronous reset mid-MEM_WAIT
    do_reset();
    mem_req = 1; mem_ready = 0;
    tick(); tick(); tick();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_outs", 32'(outs), 32'(6'b000011));
    chk("arst_state", 32'(state), 32'(S_RUN));
    chk("arst_stalls", 32'(stall_cycles), 32'd0);
    chk("arst_flag", 32'(mem_timeout), 32'd0);
    tick();
    rst = 1'b0;

    // Saturation: 350 rounds of 200 stall cycles plus one release cycle
    do_reset();
    for (int r = 0; r < 350; r++) begin
      mem_req = 1; mem_ready = 0;
      for (int c = 0; c < 200; c++) tick();
      mem_ready = 1;
      tick();
      if (r == 299) chk("sat_mid", 32'(stall_cycles), 32'd60000);
    end
    chk("sat_value", 32'(stall_cycles), 32'hFFFF);
    chk("sat_state", 32'(state), 32'(S_RUN));

    // Randomized traffic against the model
    do_reset();
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      id_valid        = 1'($urandom_range(1, 0));
      id_rs           = 5'($urandom_range(3, 0));
      id_rt           = 5'($urandom_range(3, 0));
      id_uses_rt      = 1'($urandom_range(1, 0));
      id_jump         = 2'($urandom_range(3, 0));
      ex_memread      = 1'($urandom_range(1, 0));
      ex_rd           = 5'($urandom_range(3, 0));
      ex_branch_taken = ($urandom_range(99, 0) < 20);
      mem_req         = ($urandom_range(99, 0) < 30);
      mem_ready       = 1'($urandom_range(1, 0));
      #2;
      model_predict(eo, nm);
      chk("rnd_outs", 32'(outs), 32'(eo));
      chk("rnd_state", 32'(state), 32'(m_mode));
      chk("rnd_stalls", 32'(stall_cycles), 32'(m_stalls));
      chk("rnd_flag", 32'(mem_timeout), 32'(m_to));
      tick();
      model_commit(eo, nm);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
